dly_chain_loader: RTL and testbench

- Sequencer for the shared serial configuration bus of the N ADB delay ASICs: clk_dly, din_dly, nrs_dly, per-chip active-low ncs_dly, per-chip dout_dly.
- On a start command, walks the enabled chips in ascending index order and fetches each chip's configuration word from a parallel source.
- Shifts each word MSB-first into the selected chip while capturing the chip's previous content from dout_dly for readback.
- Also issues a timed reset pulse on nrs_dly. Sits between the slow-control register file and the delay-chip pins.

---
 rtl/dly_chain_loader.sv | 253 +++++++++++++++++++++++++
 tb/tb_dly_chain_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dly_chain_loader.sv
// Serial configuration loader for the delay-chip chain.
// Walks the enabled chips in ascending order, fetches each chip's word from
// the parallel source, shifts it in MSB-first and reads back the chip's
// previous content. Also produces a timed nrs_dly reset pulse.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start / rst_req
// RST    | nrs_dly held low for RST_CYCLES cycles
// FIND   | cfg_chip already points at the lowest remaining chip; clear its bit
// FETCH  | register cfg_data into the shift register
// SETUP  | ncs low, clk_dly low, for CLK_DIV cycles
// SHIFT  | DLY_BITS bit periods; data out on din, readback in from dout
// HOLD   | ncs still low, clk/din low, CLK_DIV cycles; readback published
// FIN    | one-cycle done pulse
module dly_chain_loader #(
    parameter int N          = 7,
    parameter int DLY_BITS   = 24,
    parameter int CLK_DIV    = 4,
    parameter int RST_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [N-1:0]        chip_mask,
    input  logic                rst_req,
    output logic                busy,
    output logic                done,
    output logic [2:0]          cfg_chip,
    input  logic [DLY_BITS-1:0] cfg_data,
    output logic [DLY_BITS-1:0] rb_data,
    output logic [2:0]          rb_chip,
    output logic                rb_valid,
    output logic                clk_dly,
    output logic                din_dly,
    output logic                nrs_dly,
    output logic [N-1:0]        ncs_dly,
    input  logic [N-1:0]        dout_dly
);

    localparam int TMR_MAX = (RST_CYCLES > CLK_DIV) ? RST_CYCLES : CLK_DIV;
    localparam int TW      = $clog2(TMR_MAX);
    localparam int BW      = $clog2(DLY_BITS);

    localparam logic [TW-1:0] T_DIV_LAST = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] T_HALF     = TW'(CLK_DIV / 2);
    localparam logic [TW-1:0] T_RST_LAST = TW'(RST_CYCLES - 1);
    localparam logic [BW-1:0] B_LAST     = BW'(DLY_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_FIND, S_FETCH, S_SETUP, S_SHIFT, S_HOLD, S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        mask_q, mask_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [BW-1:0]       bits_q, bits_d;
    logic [DLY_BITS-1:0] sreg_q, sreg_d;
    logic [DLY_BITS-1:0] cap_q, cap_d;
    logic [2:0]          cfg_chip_q, cfg_chip_d;
    logic [DLY_BITS-1:0] rb_data_q, rb_data_d;
    logic [2:0]          rb_chip_q, rb_chip_d;
    logic                rb_valid_q, rb_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                clk_q, clk_d;
    logic                din_q, din_d;
    logic                nrs_q, nrs_d;
    logic [N-1:0]        ncs_q, ncs_d;
    logic                dout_sel;
    logic                sel_active;

    function automatic logic [2:0] lsb_idx(input logic [N-1:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Readback bit from the currently selected chip.
    always_comb begin
        dout_sel = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cfg_chip_q == 3'(i)) dout_sel = dout_dly[i];
        end
    end

    // Sequencer next state; pin outputs are derived from the next state so
    // every pin leaves a flop.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        tmr_d      = tmr_q;
        bits_d     = bits_q;
        sreg_d     = sreg_q;
        cap_d      = cap_q;
        cfg_chip_d = cfg_chip_q;
        rb_data_d  = rb_data_q;
        rb_chip_d  = rb_chip_q;
        rb_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rst_req) begin
                    state_d = S_RST;
                    tmr_d   = T_RST_LAST;
                end else if (start) begin
                    if (|chip_mask) begin
                        // cfg_chip moves on the edge into FIND so the source
                        // has one full cycle before FETCH samples cfg_data.
                        mask_d     = chip_mask;
                        cfg_chip_d = lsb_idx(chip_mask);
                        state_d    = S_FIND;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_RST: begin
                if (tmr_q == '0) state_d = S_FIN;
                else             tmr_d   = tmr_q - 1'b1;
            end
            S_FIND: begin
                if (mask_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        if (cfg_chip_q == 3'(i)) mask_d[i] = 1'b0;
                    end
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                sreg_d  = cfg_data;
                tmr_d   = T_DIV_LAST;
                state_d = S_SETUP;
            end
            S_SETUP: begin
                if (tmr_q == '0) begin
                    state_d = S_SHIFT;
                    tmr_d   = T_DIV_LAST;
                    bits_d  = B_LAST;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_SHIFT: begin
                // Rising clk_dly edge: capture readback, advance data.
                if (tmr_q == T_HALF) begin
                    cap_d  = {cap_q[DLY_BITS-2:0], dout_sel};
                    sreg_d = {sreg_q[DLY_BITS-2:0], 1'b0};
                end
                if (tmr_q == '0) begin
                    tmr_d = T_DIV_LAST;
                    if (bits_q == '0) state_d = S_HOLD;
                    else              bits_d  = bits_q - 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (tmr_q == '0) begin
                    rb_valid_d = 1'b1;
                    rb_data_d  = cap_q;
                    rb_chip_d  = cfg_chip_q;
                    // Look ahead at the remaining mask so the last chip
                    // finishes straight into FIN.
                    if (mask_q != '0) begin
                        cfg_chip_d = lsb_idx(mask_q);
                        state_d    = S_FIND;
                    end else begin
                        state_d = S_FIN;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_FIN);
        nrs_d      = (state_d != S_RST);
        sel_active = (state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD);
        ncs_d      = '1;
        for (int i = 0; i < N; i++) begin
            if (sel_active && (cfg_chip_d == 3'(i))) ncs_d[i] = 1'b0;
        end
        clk_d = (state_d == S_SHIFT) && (tmr_d < T_HALF);
        // din only changes in the low half of a bit period, never on the
        // rising clk_dly edge.
        if (state_d == S_SHIFT) din_d = (tmr_d >= T_HALF) ? sreg_d[DLY_BITS-1] : din_q;
        else                    din_d = 1'b0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            tmr_q      <= '0;
            bits_q     <= '0;
            sreg_q     <= '0;
            cap_q      <= '0;
            cfg_chip_q <= '0;
            rb_data_q  <= '0;
            rb_chip_q  <= '0;
            rb_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            clk_q      <= 1'b0;
            din_q      <= 1'b0;
            nrs_q      <= 1'b1;
            ncs_q      <= '1;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            tmr_q      <= tmr_d;
            bits_q     <= bits_d;
            sreg_q     <= sreg_d;
            cap_q      <= cap_d;
            cfg_chip_q <= cfg_chip_d;
            rb_data_q  <= rb_data_d;
            rb_chip_q  <= rb_chip_d;
            rb_valid_q <= rb_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            clk_q      <= clk_d;
            din_q      <= din_d;
            nrs_q      <= nrs_d;
            ncs_q      <= ncs_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign cfg_chip = cfg_chip_q;
    assign rb_data  = rb_data_q;
    assign rb_chip  = rb_chip_q;
    assign rb_valid = rb_valid_q;
    assign clk_dly  = clk_q;
    assign din_dly  = din_q;
    assign nrs_dly  = nrs_q;
    assign ncs_dly  = ncs_q;

endmodule

// File: tb/tb_dly_chain_loader.sv
// Bench for dly_chain_loader: chip models on the serial pins, a delayed
// configuration source, and a timeline model of every output per cycle.
module tb_dly_chain_loader;

    localparam int N   = 7;
    localparam int DB  = 24;
    localparam int CD  = 4;
    localparam int RC  = 16;
    localparam int PER = 2 + CD + DB * CD + CD;

    logic          clock, reset, start, rst_req;
    logic [N-1:0]  chip_mask;
    logic          busy, done, rb_valid, clk_dly, din_dly, nrs_dly;
    logic [2:0]    cfg_chip, rb_chip;
    logic [DB-1:0] cfg_data, rb_data;
    logic [N-1:0]  ncs_dly, dout_dly;

    dly_chain_loader #(.N(N), .DLY_BITS(DB), .CLK_DIV(CD), .RST_CYCLES(RC)) dut (
        .clock(clock), .reset(reset), .start(start), .chip_mask(chip_mask),
        .rst_req(rst_req), .busy(busy), .done(done), .cfg_chip(cfg_chip),
        .cfg_data(cfg_data), .rb_data(rb_data), .rb_chip(rb_chip),
        .rb_valid(rb_valid), .clk_dly(clk_dly), .din_dly(din_dly),
        .nrs_dly(nrs_dly), .ncs_dly(ncs_dly), .dout_dly(dout_dly)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int tests = 0;
    int fails = 0;

    // model state
    int            mode;          // 0 idle, 1 load, 2 chip reset
    int            t0, nch, seq_end;
    int            list[8];
    logic [DB-1:0] word[8];
    logic [DB-1:0] exp_rb[8];
    logic [DB-1:0] content[8];
    logic [DB-1:0] chip_reg[8];
    logic [DB-1:0] cfg_tab[8];
    logic [2:0]    cfg_prev = 3'd0;
    bit            chk_en;

    int            seq_busy, seq_rbv, seq_done_r, seq_nrs_low;
    logic [DB-1:0] last_rb;
    logic [2:0]    last_rbc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // delay chips: shift on clk_dly rise while selected, MSB drives dout
    always @(posedge clk_dly) begin
        for (int i = 0; i < N; i++)
            if (!ncs_dly[i]) chip_reg[i] = {chip_reg[i][DB-2:0], din_dly};
    end
    for (genvar g = 0; g < N; g++) begin : g_dout
        assign dout_dly[g] = chip_reg[g][DB-1];
    end

    // configuration source: word follows cfg_chip exactly one cycle later
    always @(posedge clock) begin
        #1;
        cfg_data = cfg_tab[cfg_prev];
        cfg_prev = cfg_chip;
    end

    // per-cycle comparison against the timeline model
    always @(negedge clock) begin : cmp
        logic          e_busy, e_done, e_clk, e_din, e_nrs, e_rbv, cfg_chk;
        logic [N-1:0]  e_ncs;
        logic [DB-1:0] e_rbd;
        logic [2:0]    e_rbc, e_cfg;
        int r, j, p, s;
        if (chk_en) begin
            e_busy = 0; e_done = 0; e_clk = 0; e_din = 0; e_nrs = 1; e_rbv = 0;
            cfg_chk = 0; e_ncs = '1; e_rbd = '0; e_rbc = '0; e_cfg = '0;
            r = cyc - t0;
            if (mode == 1) begin
                if (nch == 0) begin
                    if (r == 1) begin e_busy = 1; e_done = 1; end
                end else begin
                    if (r >= 1 && r <= seq_end) e_busy = 1;
                    if (r == seq_end) e_done = 1;
                    if (r >= 1 && r <= PER * nch) begin
                        j = (r - 1) / PER;
                        p = (r - 1) % PER;
                        e_cfg = 3'(list[j]);
                        cfg_chk = 1;
                        if (p >= 2 && p <= PER - 1) e_ncs[list[j]] = 1'b0;
                        if (p >= 2 + CD && p < 2 + CD + DB * CD) begin
                            s = p - 2 - CD;
                            e_clk = ((s % CD) >= CD / 2);
                            e_din = word[j][DB - 1 - s / CD];
                        end
                    end
                    if (r > PER && r <= seq_end && (r - 1) % PER == 0) begin
                        e_rbv = 1;
                        e_rbd = exp_rb[(r - 1) / PER - 1];
                        e_rbc = 3'(list[(r - 1) / PER - 1]);
                    end
                end
            end else if (mode == 2) begin
                if (r >= 1 && r <= RC + 1) e_busy = 1;
                if (r >= 1 && r <= RC) e_nrs = 0;
                if (r == RC + 1) e_done = 1;
            end
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("clk_dly", clk_dly, e_clk);
            chk("din_dly", din_dly, e_din);
            chk("nrs_dly", nrs_dly, e_nrs);
            chk("ncs_dly", ncs_dly, e_ncs);
            chk("rb_valid", rb_valid, e_rbv);
            if (e_rbv) begin
                chk("rb_data", rb_data, e_rbd);
                chk("rb_chip", rb_chip, e_rbc);
            end
            if (cfg_chk) chk("cfg_chip", cfg_chip, e_cfg);
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cfg_chip"}, cfg_chip, 0);
        chk({tag, "_rb_data"}, rb_data, 0);
        chk({tag, "_rb_chip"}, rb_chip, 0);
        chk({tag, "_rb_valid"}, rb_valid, 0);
        chk({tag, "_clk_dly"}, clk_dly, 0);
        chk({tag, "_din_dly"}, din_dly, 0);
        chk({tag, "_nrs_dly"}, nrs_dly, 1);
        chk({tag, "_ncs_dly"}, ncs_dly, {N{1'b1}});
    endtask

    task automatic launch(input logic [N-1:0] m, input bit do_start, input bit do_rst);
        @(posedge clock); #1;
        start = do_start; rst_req = do_rst; chip_mask = m; t0 = cyc;
        if (do_rst) begin
            mode = 2; seq_end = RC + 1;
        end else begin
            mode = 1; nch = 0;
            for (int i = 0; i < N; i++) begin
                if (m[i]) begin
                    list[nch] = i; word[nch] = cfg_tab[i]; exp_rb[nch] = content[i];
                    content[i] = cfg_tab[i];
                    nch++;
                end
            end
            seq_end = (nch == 0) ? 1 : PER * nch + 1;
        end
    endtask

    task automatic run_seq(input bit noise);
        bit seen = 0;
        seq_busy = 0; seq_rbv = 0; seq_done_r = -1; seq_nrs_low = 0;
        for (int k = 0; k < PER * N + 50 && !seen; k++) begin
            @(posedge clock); #1;
            start = 0; rst_req = 0;
            if (noise) begin
                chip_mask = N'($urandom);
                if (cyc - t0 <= seq_end - 2) begin
                    case ($urandom_range(0, 7))
                        0: start = 1;
                        1: rst_req = 1;
                        default: ;
                    endcase
                end
            end
            @(negedge clock);
            if (busy) seq_busy++;
            if (!nrs_dly) seq_nrs_low++;
            if (rb_valid) begin seq_rbv++; last_rb = rb_data; last_rbc = rb_chip; end
            if (done) begin seen = 1; seq_done_r = cyc - t0; end
        end
        chk("done_seen", seen, 1);
    endtask

    task automatic check_chips();
        for (int i = 0; i < N; i++) chk("chip_content", chip_reg[i], content[i]);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; start = 0; rst_req = 0; chip_mask = '0; chk_en = 0; mode = 0; t0 = 0;
        for (int i = 0; i < 8; i++) begin
            chip_reg[i] = DB'($urandom);
            content[i]  = chip_reg[i];
            cfg_tab[i]  = DB'($urandom);
        end
        chip_reg[0] = 24'h123456; content[0] = 24'h123456; cfg_tab[0] = 24'hA5C3F0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_vals("por");
        @(posedge clock); #1;
        reset = 0; chk_en = 1;
        repeat (20) @(posedge clock);

        // single chip, fixed words
        launch(7'b0000001, 1, 0);
        run_seq(0);
        chk("t1_done_cycle", seq_done_r, 107);
        chk("t1_busy_cycles", seq_busy, 107);
        chk("t1_rb_data", last_rb, 24'h123456);
        chk("t1_rb_chip", last_rbc, 0);
        chk("t1_chip0_loaded", chip_reg[0], 24'hA5C3F0);

        // three chips with noise on inputs while busy
        launch(7'b1010010, 1, 0);
        run_seq(1);
        chk("t2_busy_cycles", seq_busy, 3 * 106 + 1);
        chk("t2_rb_pulses", seq_rbv, 3);
        check_chips();

        // empty mask
        launch('0, 1, 0);
        run_seq(0);
        chk("t3_done_cycle", seq_done_r, 1);
        chk("t3_busy_cycles", seq_busy, 1);

        // rst_req wins over start; starts during the pulse are dropped
        launch(7'b0000011, 1, 1);
        run_seq(1);
        chk("t4_nrs_low", seq_nrs_low, 16);
        chk("t4_done_cycle", seq_done_r, 17);
        chk("t4_no_rb", seq_rbv, 0);

        // random sequences
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 8; i++) cfg_tab[i] = DB'($urandom);
            if ($urandom_range(0, 4) == 0) launch(N'($urandom), 1, 1);
            else if ($urandom_range(0, 5) == 0) launch('0, 1, 0);
            else launch(N'($urandom), 1, 0);
            run_seq(1);
            check_chips();
        end

        // reset in the middle of shifting chip 2
        for (int i = 0; i < 8; i++) cfg_tab[i] = DB'($urandom);
        launch(7'b0000100, 1, 0);
        @(posedge clock); #1; start = 0;
        repeat (45) @(posedge clock);
        #1; chk_en = 0; reset = 1;
        @(posedge clock);
        @(negedge clock);
        check_reset_vals("abort");
        @(posedge clock); #1;
        reset = 0; mode = 0;
        for (int i = 0; i < N; i++) content[i] = chip_reg[i];
        chk_en = 1;
        repeat (5) @(posedge clock);

        // reload after abort
        for (int i = 0; i < 8; i++) cfg_tab[i] = DB'($urandom);
        launch(7'b0000100 | N'($urandom), 1, 0);
        run_seq(1);
        check_chips();
        repeat (5) @(posedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
